edusoc_lsu: RTL
===============

# edusoc_lsu

Core-side load/store unit: the initiator end of the EduSoC data memory bus. It turns one load or store request from the CPU pipeline into a single word-aligned bus transaction. It drives the address, byte enables, lane-replicated write data and request, and waits for the SoC's valid response. It then returns sign- or zero-extended load data with a one-cycle completion pulse, and aborts with an error on misalignment or response timeout.

## Interface

- `TIMEOUT_CYCLES`, default 255: bus wait cycles before abort; 0 disables the timeout; legal range 0..65535.
- `clk` in 1: core clock. This is the single clock.
- `resn` in 1: reset, asynchronous and active-low.
- `op_start` in 1: start request. Sampled only in IDLE.
- `op_we` in 1: 1 = store, 0 = load.
- `op_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `op_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `op_addr` in 32: byte address.
- `op_wdata` in 32: store data; the low bits are significant.
- `op_busy` out 1: high whenever the state is not IDLE.
- `op_done` out 1: one-cycle completion pulse.
- `op_err` out 1: valid only with `op_done`; 1 = misaligned, illegal size, or timeout.
- `op_rdata` out 32: extended load result. It is held until the next `op_done`.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write enable.
- `mem_be` out 4: bus byte enables.
- `mem_addr` out 32: word-aligned bus address.
- `mem_wdata` out 32: bus write data.
- `mem_valid` in 1: responder completion, one cycle.
- `mem_rdata` in 32: read data, valid with `mem_valid`.

## Operation

- States are IDLE, WAIT and RESP.
- IDLE -> WAIT: on `op_start` with a legal, aligned request.
  - Capture all op fields.
  - Clear the timeout counter.
- IDLE -> RESP, with error: on `op_start` with `op_size`=11, half with `op_addr[0]`=1, or word with `op_addr[1:0]`≠00. No bus request is issued.
- WAIT -> RESP: on `mem_valid`=1, or when the timeout expires.
- RESP -> IDLE: unconditional. `op_start` presented in RESP is ignored.
- Bus signals are registered and held stable throughout WAIT.
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_be`:
    - byte: 0001 << addr[1:0]
    - half: 0011 << addr[1:0]
    - word: 1111
  - `mem_wdata`:
    - byte: {4{wdata[7:0]}}
    - half: {2{wdata[15:0]}}
    - word: wdata
  - `mem_we` = the captured `op_we`.
- Load extraction from `mem_rdata`:
  - byte lane = addr[1:0].
  - half lane = addr[1].
  - The result is extended per `op_unsigned`.
- Store completion sets `op_rdata` to 0. Error completion also sets `op_rdata` to 0.
- Timeout:
  - A 16-bit counter increments in each WAIT cycle with `mem_valid`=0.
  - When it reaches `TIMEOUT_CYCLES` (and that parameter is nonzero), go to RESP with `op_err`=1.
- `mem_valid` in the same cycle as expiry: the valid wins, and the result is a normal completion.
- `mem_valid` outside WAIT, including a late response after abort, is ignored.

## Timing

- Reset values: all outputs are 0 and the state is IDLE. Reset asserted mid-transaction drops `mem_req` immediately, with no completion pulse.
- Cycle 0: `op_start` is sampled. Cycle 1: `mem_req`=1 with stable addr/be/we/wdata.
- The responder may assert `mem_valid` in any cycle where `mem_req`=1, including the first.
- `mem_valid` in cycle k:
  - `mem_req`=0 in cycle k+1.
  - `op_done` pulses in cycle k+1, with `op_rdata`/`op_err` updated in the same cycle.
- Minimum latency, `op_start` to `op_done`: 2 cycles. Back-to-back throughput: one op per 3 cycles.
- Error path: `op_done`=`op_err`=1 in cycle 1, and `mem_req` never rises.
- Timeout:
  - `mem_req` rises in cycle 1.
  - If no valid arrives, `op_done`/`op_err` pulse in cycle `TIMEOUT_CYCLES`+1.
  - `mem_req` is 0 in that same cycle.
- `op_busy`=1 from cycle 1 through the `op_done` cycle inclusive.

## Test plan

- Load byte, `op_addr`=0x1003, signed, `mem_rdata`=0x80AA_BBCC, valid in the first req cycle.
  - Bus: `mem_addr`=0x1000, `mem_be`=1000.
  - Result: `op_rdata`=0xFFFF_FF80 on `op_done` 2 cycles after start.
  - Repeat unsigned: `op_rdata`=0x0000_0080.
- Store half, `op_addr`=0x2002, `op_wdata`=0x1234_5678; valid 5 cycles after req.
  - Bus: `mem_be`=1100, `mem_wdata`=0x5678_5678, `mem_we`=1, all held stable for 5 cycles.
  - Result: `op_done` with `op_err`=0 and `op_rdata`=0.
- Word load at 0x3001.
  - `op_done`=`op_err`=1 one cycle after start, and `mem_req` never rises.
  - Same outcome for `op_size`=11 at 0x3000.
- `TIMEOUT_CYCLES`=4, no `mem_valid`.
  - `mem_req` is high cycles 1–4, and `op_done`/`op_err` pulse in cycle 5.
  - A late `mem_valid` in cycle 6 is ignored.
- `TIMEOUT_CYCLES`=4, `mem_valid` in cycle 4 with `mem_rdata`=0xDEAD_BEEF, word load.
  - Normal completion: `op_err`=0, `op_rdata`=0xDEAD_BEEF.
- `resn` asserted in the 3rd WAIT cycle.
  - All outputs go to 0 immediately, with no `op_done`.
  - After release, a new word load at 0x0 completes normally.

Source files
------------

// File: rtl/edusoc_lsu.sv
// edusoc_lsu: core-side load/store unit for the EduSoC data memory bus.
// Turns one CPU load/store into a single word-aligned bus transaction.
// Bus outputs are held stable for the whole wait. Load data is lane-extracted
// and sign- or zero-extended. Misaligned or illegal requests complete at once
// with an error, and a stalled bus aborts after TIMEOUT_CYCLES wait cycles.
module edusoc_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resn,
    input  logic        op_start,
    input  logic        op_we,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_busy,
    output logic        op_done,
    output logic        op_err,
    output logic [31:0] op_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Captured request and bus registers
    logic [15:0] r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_uns;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_illegal;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // A zero limit disables the timeout; otherwise expire on the wait cycle
    // that would bring the counter up to the limit.
    assign w_expire = (TO_LIMIT != 16'd0) && ((r_cnt + 16'd1) == TO_LIMIT);

    // Flag illegal sizes and addresses not aligned to the access size
    always_comb begin
        w_illegal = 1'b0;
        case (op_size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = op_addr[0];
            2'b10:   w_illegal = |op_addr[1:0];
            default: w_illegal = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated write data for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = op_wdata;
        case (op_size)
            2'b00: begin
                w_be    = 4'b0001 << op_addr[1:0];
                w_wdata = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << op_addr[1:0];
                w_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = op_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the response word and extend it
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a response or an expiry ends the wait; RESP lasts one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_start) begin
                    w_next = w_illegal ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_valid || w_expire) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        op_busy = (r_state != S_IDLE);
        op_done = (r_state == S_RESP);
        mem_req = (r_state == S_WAIT);
    end

    assign op_err    = r_err;
    assign op_rdata  = r_rdata;
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Capture the request on start, then resolve the completion result
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_cnt   <= 16'd0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        if (w_illegal) begin
                            // Rejected before the bus sees anything
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_addr  <= {op_addr[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_we    <= op_we;
                            r_size  <= op_size;
                            r_lane  <= op_addr[1:0];
                            r_uns   <= op_unsigned;
                            r_cnt   <= 16'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        // A response on the expiry cycle still counts as success
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? 32'd0 : w_load;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
